ddram_clear_checker: RTL and testbench

- Read-back counterpart to the menu core's SDRAM/DDR3 clear writer.
- Scans a DDR3 region over the DDRAM Avalon-MM burst read port.
- Compares every returned 64-bit word against an expected value and reports pass/fail, an error count and the first failing address.
- Sits beside the clear writer in the menu core. It is started after the clear to prove RAM is clean before a core is launched.

---
 rtl/ddram_chk_pkg.sv | 38 +++
 rtl/ddram_beat_checker.sv | 39 +++
 rtl/ddram_clear_checker.sv | 143 ++++++++++++++
 tb/tb_ddram_clear_checker.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddram_chk_pkg.sv
// Shared types and helpers for the DDRAM read-back clear checker.
// Define DDRAM_CHECK_PATTERN_EN to check the address-pattern word instead of a fixed EXPECT word.
package ddram_chk_pkg;

  localparam int DDR_ADDR_W = 29;
  localparam int DDR_DATA_W = 64;
  localparam logic [7:0] BE_ALL = 8'hFF;

`ifdef DDRAM_CHECK_PATTERN_EN
  localparam bit PATTERN_EN = 1'b1;
`else
  localparam bit PATTERN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, DATA, FIN} chk_state_t;

  function automatic logic [DDR_DATA_W-1:0] expect_word(
    input logic [DDR_ADDR_W-1:0] addr,
    input logic [DDR_DATA_W-1:0] fixed_word
  );
    if (PATTERN_EN)
      expect_word = {3'b000, ~addr, 3'b000, addr};
    else
      expect_word = fixed_word;
  endfunction

  // Beats for the next burst: the full burst length unless fewer words remain.
  function automatic logic [7:0] burst_beats(
    input logic [DDR_ADDR_W-1:0] remaining,
    input logic [7:0]            max_len
  );
    if (remaining > {{(DDR_ADDR_W-8){1'b0}}, max_len})
      burst_beats = max_len;
    else
      burst_beats = remaining[7:0];
  endfunction

endpackage

// File: rtl/ddram_beat_checker.sv
// Registered per-beat compare with a saturating error counter and first-failure address capture.
module ddram_beat_checker
  import ddram_chk_pkg::*;
#(
  parameter logic [DDR_DATA_W-1:0] EXPECT = '0
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  valid,
  input  logic [DDR_ADDR_W-1:0] addr,
  input  logic [DDR_DATA_W-1:0] data,
  output logic [15:0]           err_count,
  output logic [DDR_ADDR_W-1:0] first_err_addr
);

  logic                  mismatch_q;
  logic [DDR_ADDR_W-1:0] mismatch_addr_q;

  // The compare result is registered first, so the counter lands one cycle after the beat.
  always_ff @(posedge clk_sys) begin
    if (!reset_n || clr) begin
      mismatch_q      <= 1'b0;
      mismatch_addr_q <= '0;
      err_count       <= '0;
      first_err_addr  <= '0;
    end else begin
      mismatch_q      <= valid && (data != expect_word(addr, EXPECT));
      mismatch_addr_q <= addr;
      if (mismatch_q) begin
        if (err_count == 16'd0)
          first_err_addr <= mismatch_addr_q;
        if (err_count != 16'hFFFF)
          err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: rtl/ddram_clear_checker.sv
// Scans a DDR3 region over the DDRAM Avalon-MM burst read port and reports pass/fail.
// Optional: DDRAM_CHECK_PATTERN_EN selects the address-pattern expected word.
module ddram_clear_checker
  import ddram_chk_pkg::*;
#(
  parameter logic [DDR_ADDR_W-1:0] BASE_ADDR = 29'h0000000,
  parameter logic [DDR_ADDR_W-1:0] WORDS     = 29'h0100000,
  parameter logic [7:0]            BURST_LEN = 8'd128,
  parameter logic [DDR_DATA_W-1:0] EXPECT    = 64'h0
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [DDR_ADDR_W-1:0] first_err_addr,
  input  logic                  DDRAM_BUSY,
  output logic [7:0]            DDRAM_BURSTCNT,
  output logic [DDR_ADDR_W-1:0] DDRAM_ADDR,
  output logic                  DDRAM_RD,
  output logic [7:0]            DDRAM_BE,
  input  logic [DDR_DATA_W-1:0] DDRAM_DOUT,
  input  logic                  DDRAM_DOUT_READY
);

  chk_state_t state, state_nx;

  logic [DDR_ADDR_W-1:0] addr_q, addr_nx;
  logic [DDR_ADDR_W-1:0] remaining_q, remaining_nx;
  logic [DDR_ADDR_W-1:0] rem_left;
  logic [7:0]            burst_q, burst_nx;
  logic [7:0]            beat_idx_q, beat_idx_nx;
  logic                  drain_q, drain_nx;
  logic                  pass_q, pass_nx;
  logic                  clr;
  logic                  beat_valid;
  logic [DDR_ADDR_W-1:0] beat_addr;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      burst_q     <= '0;
      beat_idx_q  <= '0;
      drain_q     <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      addr_q      <= addr_nx;
      remaining_q <= remaining_nx;
      burst_q     <= burst_nx;
      beat_idx_q  <= beat_idx_nx;
      drain_q     <= drain_nx;
      pass_q      <= pass_nx;
    end
  end

  // drain_q holds DATA one extra cycle after the final beat so FIN sees the settled error count.
  always_comb begin
    state_nx     = state;
    addr_nx      = addr_q;
    remaining_nx = remaining_q;
    burst_nx     = burst_q;
    beat_idx_nx  = beat_idx_q;
    drain_nx     = drain_q;
    pass_nx      = pass_q;
    rem_left     = remaining_q - {{(DDR_ADDR_W-8){1'b0}}, burst_q};
    clr          = 1'b0;
    beat_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clr          = 1'b1;
          pass_nx      = 1'b0;
          addr_nx      = BASE_ADDR;
          remaining_nx = WORDS;
          burst_nx     = burst_beats(WORDS, BURST_LEN);
          beat_idx_nx  = '0;
          drain_nx     = 1'b0;
          state_nx     = REQ;
        end
      end
      REQ: begin
        if (!DDRAM_BUSY) begin
          beat_idx_nx = '0;
          state_nx    = DATA;
        end
      end
      DATA: begin
        if (drain_q) begin
          drain_nx = 1'b0;
          state_nx = FIN;
        end else if (DDRAM_DOUT_READY) begin
          beat_valid = 1'b1;
          if (beat_idx_q == burst_q - 8'd1) begin
            addr_nx      = addr_q + {{(DDR_ADDR_W-8){1'b0}}, burst_q};
            remaining_nx = rem_left;
            beat_idx_nx  = '0;
            if (rem_left == '0) begin
              drain_nx = 1'b1;
            end else begin
              burst_nx = burst_beats(rem_left, BURST_LEN);
              state_nx = REQ;
            end
          end else begin
            beat_idx_nx = beat_idx_q + 8'd1;
          end
        end
      end
      FIN: begin
        pass_nx  = (err_count == 16'd0);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign beat_addr      = addr_q + {{(DDR_ADDR_W-8){1'b0}}, beat_idx_q};
  assign DDRAM_RD       = (state == REQ);
  assign DDRAM_ADDR     = addr_q;
  assign DDRAM_BURSTCNT = burst_q;
  assign DDRAM_BE       = BE_ALL;
  assign busy           = (state == REQ) || (state == DATA);
  assign done           = (state == FIN);
  assign pass           = (state == FIN) ? (err_count == 16'd0) : pass_q;

  ddram_beat_checker #(
    .EXPECT(EXPECT)
  ) u_beat_checker (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .clr           (clr),
    .valid         (beat_valid),
    .addr          (beat_addr),
    .data          (DDRAM_DOUT),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

endmodule

// File: tb/tb_ddram_clear_checker.sv
// Scoreboard bench for ddram_clear_checker: a small 10-word scan DUT plus a long saturation DUT.
module tb_ddram_clear_checker;

  localparam logic [28:0] M_BASE   = 29'h0;
  localparam int          M_WORDS  = 10;
  localparam logic [7:0]  M_BL     = 8'd4;
  localparam logic [63:0] M_EXPECT = 64'h0;
  localparam logic [28:0] S_BASE   = 29'h1FFF_FF00;
  localparam logic [28:0] S_WORDS  = 29'd65600;
  localparam logic [7:0]  S_BL     = 8'd128;
  localparam logic [15:0] S_ERR    = (S_WORDS > 29'd65535) ? 16'hFFFF : S_WORDS[15:0];

  logic        clk_sys;
  logic        reset_n, start, busy, done, pass;
  logic [15:0] err_count;
  logic [28:0] first_err_addr, ddr_addr;
  logic        ddr_busy, ddr_rd, ddr_ready;
  logic [7:0]  ddr_burstcnt, ddr_be;
  logic [63:0] ddr_dout;

  logic        s_reset_n, s_start, s_busy, s_done, s_pass;
  logic [15:0] s_err_count;
  logic [28:0] s_first_err_addr, s_ddr_addr;
  logic        s_ddr_busy, s_ddr_rd, s_ddr_ready;
  logic [7:0]  s_ddr_burstcnt, s_ddr_be;
  logic [63:0] s_ddr_dout;

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] mem [M_WORDS];
  logic [36:0] exp_req[$];
  logic [36:0] acc_q[$];
  logic [45:0] exp_done[$];
  bit          last_exp_pass;
  bit          rand_timing = 1'b0;
  bit          hold_armed = 1'b0;
  bit          sat_seen = 1'b0;
  int          slave_left = 0;
  int          beats_done = 0;
  int          req_seen = 0;
  int          hold_left = 0;
  logic [28:0] beat_addr = '0;
  logic [28:0] hold_addr;
  logic [7:0]  hold_cnt;

  ddram_clear_checker #(
    .BASE_ADDR(M_BASE), .WORDS(29'(M_WORDS)), .BURST_LEN(M_BL), .EXPECT(M_EXPECT)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
    .DDRAM_BUSY(ddr_busy), .DDRAM_BURSTCNT(ddr_burstcnt), .DDRAM_ADDR(ddr_addr),
    .DDRAM_RD(ddr_rd), .DDRAM_BE(ddr_be), .DDRAM_DOUT(ddr_dout), .DDRAM_DOUT_READY(ddr_ready)
  );

  ddram_clear_checker #(
    .BASE_ADDR(S_BASE), .WORDS(S_WORDS), .BURST_LEN(S_BL), .EXPECT(64'h0)
  ) dut_sat (
    .clk_sys(clk_sys), .reset_n(s_reset_n), .start(s_start), .busy(s_busy), .done(s_done),
    .pass(s_pass), .err_count(s_err_count), .first_err_addr(s_first_err_addr),
    .DDRAM_BUSY(s_ddr_busy), .DDRAM_BURSTCNT(s_ddr_burstcnt), .DDRAM_ADDR(s_ddr_addr),
    .DDRAM_RD(s_ddr_rd), .DDRAM_BE(s_ddr_be), .DDRAM_DOUT(s_ddr_dout), .DDRAM_DOUT_READY(s_ddr_ready)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  function automatic logic [63:0] tb_expect(input logic [28:0] a);
`ifdef DDRAM_CHECK_PATTERN_EN
    return {3'b000, ~a, 3'b000, a};
`else
    return M_EXPECT;
`endif
  endfunction

  function automatic logic [63:0] mem_at(input logic [28:0] a);
    logic [28:0] idx;
    idx = a - M_BASE;
    if (idx < 29'(M_WORDS)) return mem[idx];
    return 64'hBAD0_BAD0_BAD0_BAD0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model: expected bursts and final status derived from the memory image.
  task automatic applyStimulus();
    int          errs;
    logic [28:0] first, a, rem;
    logic [7:0]  n;
    errs = 0;
    first = '0;
    for (int w = 0; w < M_WORDS; w++) begin
      a = M_BASE + 29'(w);
      if (mem[w] != tb_expect(a)) begin
        if (errs == 0) first = a;
        errs++;
      end
    end
    a = M_BASE;
    rem = 29'(M_WORDS);
    while (rem != 0) begin
      n = (rem > 29'(M_BL)) ? M_BL : rem[7:0];
      exp_req.push_back({a, n});
      a = a + 29'(n);
      rem = rem - 29'(n);
    end
    last_exp_pass = (errs == 0);
    exp_done.push_back({last_exp_pass, (errs > 65535) ? 16'hFFFF : 16'(errs), first});
    repeat (2) @(negedge clk_sys);
    req_seen = 0;
    beats_done = 0;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
  endtask

  task automatic waitScan();
    int c;
    c = 0;
    while (exp_done.size() != 0 && c < 400) begin
      @(negedge clk_sys);
      c++;
    end
    checkOutput("scan_timeout", 64'(exp_done.size()), 64'd0);
    checkOutput("bursts_left", 64'(exp_req.size()), 64'd0);
    exp_done.delete();
    exp_req.delete();
    repeat (2) @(negedge clk_sys);
    checkOutput("pass_held", 64'(pass), 64'(last_exp_pass));
  endtask

  // Avalon slave for the main DUT: random waitrequest, ready gaps and stray ready outside bursts.
  initial begin : slave
    ddr_busy = 1'b0;
    ddr_ready = 1'b0;
    ddr_dout = '0;
    forever begin
      @(negedge clk_sys);
      if (slave_left > 0 && (!rand_timing || $urandom_range(0, 3) != 0)) begin
        ddr_ready = 1'b1;
        ddr_dout = mem_at(beat_addr);
        beat_addr = beat_addr + 29'd1;
        slave_left--;
        beats_done++;
      end else if (slave_left == 0 && rand_timing && $urandom_range(0, 7) == 0) begin
        ddr_ready = 1'b1;
        ddr_dout = {$urandom, $urandom};
      end else begin
        ddr_ready = 1'b0;
        ddr_dout = '0;
      end
      if (hold_armed && ddr_rd && req_seen == 1) begin
        hold_left = 7;
        hold_armed = 1'b0;
      end
      if (hold_left > 0) begin
        ddr_busy = 1'b1;
        hold_left--;
        checkOutput("hold_stable", 64'({ddr_rd, ddr_addr, ddr_burstcnt}), 64'({1'b1, hold_addr, hold_cnt}));
      end else begin
        ddr_busy = rand_timing && ($urandom_range(0, 2) == 0);
      end
      if (ddr_rd && !ddr_busy) begin
        acc_q.push_back({ddr_addr, ddr_burstcnt});
        slave_left = int'(ddr_burstcnt);
        beat_addr = ddr_addr;
        req_seen++;
      end
    end
  end

  // Slave for the saturation DUT: every beat is all-ones; burst addresses tracked with wraparound.
  initial begin : sat_slave
    int          left;
    logic [28:0] nxt, rem;
    logic [7:0]  n;
    left = 0;
    nxt = S_BASE;
    rem = S_WORDS;
    s_ddr_busy = 1'b0;
    s_ddr_ready = 1'b0;
    s_ddr_dout = '1;
    forever begin
      @(negedge clk_sys);
      if (left > 0) begin
        s_ddr_ready = 1'b1;
        left--;
      end else begin
        s_ddr_ready = 1'b0;
        if (s_ddr_rd) begin
          n = (rem > 29'(S_BL)) ? S_BL : rem[7:0];
          checkOutput("sat_burst", 64'({s_ddr_addr, s_ddr_burstcnt}), 64'({nxt, n}));
          left = int'(s_ddr_burstcnt);
          nxt = nxt + 29'(n);
          rem = rem - 29'(n);
        end
      end
    end
  end

  initial begin : monitor
    logic [36:0] got;
    forever begin
      @(posedge clk_sys);
      #1;
      while (acc_q.size() != 0) begin
        got = acc_q.pop_front();
        checkOutput("burst_expected", 64'(exp_req.size() != 0), 64'd1);
        if (exp_req.size() != 0) checkOutput("burst_req", 64'(got), 64'(exp_req.pop_front()));
      end
      if (done) begin
        checkOutput("done_expected", 64'(exp_done.size() != 0), 64'd1);
        if (exp_done.size() != 0)
          checkOutput("done_status", 64'({busy, pass, err_count, first_err_addr}), 64'({1'b0, exp_done.pop_front()}));
      end
      if (s_done) begin
        checkOutput("sat_status", 64'({s_busy, s_pass, s_err_count, s_first_err_addr}), 64'({1'b0, 1'b0, S_ERR, S_BASE}));
        sat_seen = 1'b1;
      end
    end
  end

  initial begin : stimulus
    int c;
    reset_n = 1'b0;
    s_reset_n = 1'b0;
    start = 1'b0;
    s_start = 1'b0;
    for (int w = 0; w < M_WORDS; w++) mem[w] = tb_expect(M_BASE + 29'(w));
    repeat (3) @(negedge clk_sys);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_pass", 64'(pass), 64'd0);
    checkOutput("rst_rd", 64'(ddr_rd), 64'd0);
    checkOutput("rst_err_count", 64'(err_count), 64'd0);
    checkOutput("rst_first_err", 64'(first_err_addr), 64'd0);
    checkOutput("rst_addr", 64'(ddr_addr), 64'd0);
    checkOutput("rst_burstcnt", 64'(ddr_burstcnt), 64'd0);
    checkOutput("be_const", 64'(ddr_be), 64'hFF);
    reset_n = 1'b1;
    s_reset_n = 1'b1;
    @(negedge clk_sys);
    s_start = 1'b1;
    @(negedge clk_sys);
    s_start = 1'b0;

    $display("[TB] basic scan");
    applyStimulus();
    waitScan();

    $display("[TB] waitrequest on second request");
    hold_addr = M_BASE + 29'(M_BL);
    hold_cnt = (M_WORDS - int'(M_BL) > int'(M_BL)) ? M_BL : 8'(M_WORDS - int'(M_BL));
    hold_armed = 1'b1;
    applyStimulus();
    waitScan();

    $display("[TB] mismatches at words 5 and 7");
    mem[5] = tb_expect(M_BASE + 29'd5) ^ 64'h1;
    mem[7] = tb_expect(M_BASE + 29'd7) ^ 64'h1;
    applyStimulus();
    waitScan();

    $display("[TB] randomized scans");
    rand_timing = 1'b1;
    for (int s = 0; s < 10; s++) begin
      for (int w = 0; w < M_WORDS; w++)
        mem[w] = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : tb_expect(M_BASE + 29'(w));
      applyStimulus();
      waitScan();
    end
    rand_timing = 1'b0;

    $display("[TB] reset during second beat");
    for (int w = 0; w < M_WORDS; w++) mem[w] = ~tb_expect(M_BASE + 29'(w));
    applyStimulus();
    c = 0;
    while (beats_done < 2 && c < 50) begin
      @(negedge clk_sys);
      #1;
      c++;
    end
    checkOutput("beat2_reached", 64'(beats_done >= 2), 64'd1);
    reset_n = 1'b0;
    exp_req.delete();
    exp_done.delete();
    @(posedge clk_sys);
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_rd", 64'(ddr_rd), 64'd0);
    checkOutput("abort_err_count", 64'(err_count), 64'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    c = 0;
    while (slave_left != 0 && c < 50) begin
      @(negedge clk_sys);
      c++;
    end
    repeat (4) @(negedge clk_sys);
    checkOutput("trailing_err_count", 64'(err_count), 64'd0);
    checkOutput("trailing_busy", 64'(busy), 64'd0);
    for (int w = 0; w < M_WORDS; w++) mem[w] = tb_expect(M_BASE + 29'(w));
    applyStimulus();
    waitScan();

    c = 0;
    while (!sat_seen && c < 70000) begin
      @(negedge clk_sys);
      c++;
    end
    checkOutput("sat_done_seen", 64'(sat_seen), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
